// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg
// Purpose : shared register-file constants for the 16-bit RISC-V core.
//           They cover the data/address widths, the register count and the
//           index of each writeback source on the arbiter request vector.
// Contents: RF_DW, RF_AW, RF_NREGS, RF_NREQ, WB_* source indices.
package regfile_wr_arbiter_pkg;

  localparam int RF_DW    = 16;
  localparam int RF_AW    = 3;
  localparam int RF_NREGS = 8;

  // Writeback source positions on req[] / ack[]
  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_LINK = 2;
  localparam int WB_CSR  = 3;

  localparam int RF_NREQ = 4;

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// rr_pick
// Purpose : combinational round-robin search. It returns the first set bit of
//           elig, scanning upward from ptr and wrapping N_REQ-1 -> 0.
// Ports   : elig  [N_REQ-1:0] eligible requesters
//           ptr   [AW-1:0]    search start index (always < N_REQ)
//           found             any bit of elig set
//           idx   [AW-1:0]    winning requester index (0 when !found)
module rr_pick
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = RF_NREQ,
  parameter int AW    = RF_AW
) (
  input  logic [N_REQ-1:0] elig,
  input  logic [AW-1:0]    ptr,
  output logic             found,
  output logic [AW-1:0]    idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [AW:0]        w_sum;

  // Rotating the doubled vector puts requester ptr at bit 0, so the lowest
  // set bit of w_rot is the nearest eligible requester at or after ptr.
  assign w_dbl = {elig, elig} >> ptr;
  assign w_rot = w_dbl[N_REQ-1:0];

  // Priority scan of the rotated vector, then map the offset back to an index
  always_comb begin
    found = 1'b0;
    w_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      // Descending scan: the last hit written is the lowest offset.
      found = found | w_rot[k];
      w_sum = w_rot[k] ? ({1'b0, ptr} + (AW+1)'(k)) : w_sum;
    end
    if (w_sum >= (AW+1)'(N_REQ)) begin
      idx = AW'(w_sum - (AW+1)'(N_REQ));
    end else begin
      idx = w_sum[AW-1:0];
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Purpose : shares the single register-file write port among N_REQ writeback
//           sources. Arbitration is round-robin with one write per cycle and
//           a registered req/ack handshake.
// Ports   : clk, rst (synchronous, active-high)
//           req      [N_REQ]    level request, held until ack
//           req_addr [N_REQ*AW] requester i at [i*AW +: AW]
//           req_data [N_REQ*DW] requester i at [i*DW +: DW]
//           ack      [N_REQ]    one-hot grant pulse (registered)
//           wr_en/wr_addr/wr_data register-file write port (registered)
//           busy                any unmasked request pending (combinational)
// Option  : define RF_R0_ZERO_EN to treat register 0 as read-only zero. A grant
//           to address 0 still acks and advances the pointer, but wr_en stays 0.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = RF_NREQ,
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [DW-1:0]       wr_data,
  output logic                busy
);

  logic [N_REQ-1:0] r_ack;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [DW-1:0]    r_wr_data;
  logic [AW-1:0]    r_rr_ptr;

  logic [N_REQ-1:0] w_elig;
  logic             w_found;
  logic [AW-1:0]    w_idx;
  logic [N_REQ-1:0] w_onehot;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic             w_sel_wr;
  logic [AW-1:0]    w_ptr_next;

  // A requester still holding req in its ack cycle must not be granted twice.
  assign w_elig = req & ~r_ack;
  assign busy   = |w_elig;

  rr_pick #(
    .N_REQ (N_REQ),
    .AW    (AW)
  ) u_pick (
    .elig  (w_elig),
    .ptr   (r_rr_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Winner mux: one-hot grant plus the winner's address and data
  always_comb begin
    w_onehot   = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_onehot[i] = (w_idx == AW'(i));
      w_sel_addr  = (w_idx == AW'(i)) ? req_addr[i*AW +: AW] : w_sel_addr;
      w_sel_data  = (w_idx == AW'(i)) ? req_data[i*DW +: DW] : w_sel_data;
    end
  end

  // Next round-robin pointer: one past the winner, wrapping at N_REQ
  always_comb begin
    w_ptr_next = '0;
    if (w_idx == AW'(N_REQ - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_idx + AW'(1);
    end
  end

`ifdef RF_R0_ZERO_EN
  // Register 0 is hard-wired zero, so a write to it is acked but not issued.
  assign w_sel_wr = (w_sel_addr != '0);
`else
  assign w_sel_wr = 1'b1;
`endif

  // Grant / write-port registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rr_ptr  <= '0;
    end else if (w_found) begin
      r_ack     <= w_onehot;
      r_wr_en   <= w_sel_wr;
      r_wr_addr <= w_sel_addr;
      r_wr_data <= w_sel_data;
      r_rr_ptr  <= w_ptr_next;
    end else begin
      // Idle: address/data keep their last values.
      r_ack   <= '0;
      r_wr_en <= 1'b0;
    end
  end

  assign ack     = r_ack;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
// Purpose : self-checking bench for regfile_wr_arbiter. Every stepped cycle
//           pushes the expected write-port state, taken from a reference
//           model of the arbitration rules, to a scoreboard. Each test task
//           pops that entry after the edge and also checks the test-plan
//           values directly.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int N  = RF_NREQ;
  localparam int DW = RF_DW;
  localparam int AW = RF_AW;

  typedef struct packed {
    logic [N-1:0]  ack;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            busy;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  // Reference model state
  logic [N-1:0]  m_ack;
  logic [AW-1:0] m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_en;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  function automatic int model_pick(input logic [N-1:0] elig, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Predict the outcome of the coming edge, queue it, advance one cycle.
  task automatic step();
    exp_t e;
    int   w;
    if (rst) begin
      m_ack = '0; m_en = 1'b0; m_ptr = '0; m_addr = '0; m_data = '0;
    end else begin
      w = model_pick(req & ~m_ack, int'(m_ptr));
      if (w >= 0) begin
        m_ack  = N'(1) << w;
        m_addr = req_addr[w*AW +: AW];
        m_data = req_data[w*DW +: DW];
`ifdef RF_R0_ZERO_EN
        m_en   = (m_addr != '0);
`else
        m_en   = 1'b1;
`endif
        m_ptr  = AW'((w + 1) % N);
      end else begin
        m_ack = '0;
        m_en  = 1'b0;
      end
    end
    e.ack = m_ack; e.en = m_en; e.addr = m_addr; e.data = m_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i*DW +: DW] = 16'h1100 + 16'(i);
    end
    for (int c = 0; c < 2; c++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({ack, wr_en, wr_addr, wr_data} !== e || ack !== 4'b0000 || wr_en !== 1'b0) begin
        n_fails++;
        $display("FAIL reset_hold c%0d: got %h want %h", c, {ack, wr_en, wr_addr, wr_data}, e);
      end
    end
    rst = 1'b0;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e || ack !== 4'b0001 || wr_data !== 16'h1100) begin
      n_fails++;
      $display("FAIL reset_release: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
  endtask

  task automatic test_single();
    exp_t e;
    req = 4'b0000;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e || wr_en !== 1'b0) begin
      n_fails++;
      $display("FAIL single_idle: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
    req = 4'b0010;
    req_addr[1*AW +: AW] = 3'd5;
    req_data[1*DW +: DW] = 16'hBEEF;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e ||
        {ack, wr_en, wr_addr, wr_data} !== {4'b0010, 1'b1, 3'd5, 16'hBEEF}) begin
      n_fails++;
      $display("FAIL single_grant: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
    req = 4'b0000;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e || wr_en !== 1'b0 || ack !== 4'b0000) begin
      n_fails++;
      $display("FAIL single_drop: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
  endtask

  task automatic test_round_robin();
    exp_t         e;
    logic [N-1:0] prev_ack;
    rst = 1'b1;
    step();
    e = sb.pop_front();
    rst = 1'b0;
    req = 4'b1111;
    prev_ack = 4'b0000;
    for (int c = 0; c < 8; c++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({ack, wr_en, wr_addr, wr_data} !== e || ack !== (4'b0001 << (c % 4)) ||
          wr_en !== 1'b1 || ack === prev_ack || busy !== 1'b1) begin
        n_fails++;
        $display("FAIL rr c%0d: got %h busy=%b want %h busy=1", c, {ack, wr_en, wr_addr, wr_data}, busy, e);
      end
      prev_ack = e.ack;
      // The acked requester presents its next write (same address, new data).
      for (int i = 0; i < N; i++) begin
        if (e.ack[i]) req_data[i*DW +: DW] = 16'hA000 + 16'(c * 16 + i);
      end
    end
  endtask

  task automatic test_ack_mask();
    exp_t e;
    req = 4'b0000;
    step();
    e = sb.pop_front();
    req = 4'b0100;
    req_addr[2*AW +: AW] = 3'd3;
    req_data[2*DW +: DW] = 16'h5A5A;
    for (int c = 0; c < 4; c++) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if ({ack, wr_en, wr_addr, wr_data} !== e || ack[2] !== ((c % 2) == 0) ||
          wr_en !== ack[2] || busy !== ~e.ack[2]) begin
        n_fails++;
        $display("FAIL ack_mask c%0d: got %h busy=%b want %h", c, {ack, wr_en, wr_addr, wr_data}, busy, e);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    exp_t e;
    req = 4'b0000;
    step();
    e = sb.pop_front();
    req = 4'b1000;
    req_addr[3*AW +: AW] = 3'd6;
    req_data[3*DW +: DW] = 16'hCAFE;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e || ack !== 4'b1000) begin
      n_fails++;
      $display("FAIL rstmid_grant: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
    rst = 1'b1;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e || ack !== 4'b0000 || wr_en !== 1'b0) begin
      n_fails++;
      $display("FAIL rstmid_clear: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
    rst = 1'b0;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e ||
        {ack, wr_en, wr_addr, wr_data} !== {4'b1000, 1'b1, 3'd6, 16'hCAFE}) begin
      n_fails++;
      $display("FAIL rstmid_regrant: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
  endtask

  task automatic test_r0();
    exp_t e;
    logic exp_en;
`ifdef RF_R0_ZERO_EN
    exp_en = 1'b0;
`else
    exp_en = 1'b1;
`endif
    req = 4'b0000;
    step();
    e = sb.pop_front();
    req = 4'b0001;
    req_addr[0 +: AW] = 3'd0;
    req_data[0 +: DW] = 16'h1234;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e ||
        {ack, wr_en, wr_addr, wr_data} !== {4'b0001, exp_en, 3'd0, 16'h1234}) begin
      n_fails++;
      $display("FAIL r0_write: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
    req = 4'b0000;
    step();
    e = sb.pop_front();
    n_checks++;
    if ({ack, wr_en, wr_addr, wr_data} !== e || ack !== 4'b0000) begin
      n_fails++;
      $display("FAIL r0_idle: got %h want %h", {ack, wr_en, wr_addr, wr_data}, e);
    end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ack_mask();
    test_reset_mid_grant();
    test_r0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
